// File: rtl/grf_hazard_if.sv
// D-stage view of the GRF read guard: operand/destination info in, stall and
// forward selects out. The pipeline drives through master, the hazard unit is the slave.
interface grf_hazard_if #(
    parameter int ADDR_W = 5,
    parameter int T_W    = 2,
    parameter int CNT_W  = 32
);
    logic              DValid;
    logic [ADDR_W-1:0] RsAddrD;
    logic [T_W-1:0]    RsTuseD;
    logic [ADDR_W-1:0] RtAddrD;
    logic [T_W-1:0]    RtTuseD;
    logic [ADDR_W-1:0] DstAddrD;
    logic              DstWriteD;
    logic [T_W-1:0]    DstTnewD;
    logic              Stall;
    logic [1:0]        FwdRsD;
    logic [1:0]        FwdRtD;
    logic [CNT_W-1:0]  StallCount;

    modport master (
        output DValid, RsAddrD, RsTuseD, RtAddrD, RtTuseD,
               DstAddrD, DstWriteD, DstTnewD,
        input  Stall, FwdRsD, FwdRtD, StallCount
    );

    modport slave (
        input  DValid, RsAddrD, RsTuseD, RtAddrD, RtTuseD,
               DstAddrD, DstWriteD, DstTnewD,
        output Stall, FwdRsD, FwdRtD, StallCount
    );
endinterface

// File: rtl/grf_hazard_unit.sv
// Read-side guard for the GRF: shadows {addr, write, Tnew} of E/M/W and resolves
// stall and forward selects for the two D-stage operands.
module grf_hazard_unit #(
    parameter int ADDR_W = 5,
    parameter int T_W    = 2,
    parameter int CNT_W  = 32
) (
    input  logic       Clk,
    input  logic       Reset,
    grf_hazard_if.slave hz
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic [T_W-1:0]    tnew;
    } rec_t;

    rec_t             e_q, e_d, m_q, m_d, w_q, w_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall;
    logic [1:0]       fwd_rs, fwd_rt;

    // Register $0 is hardwired, so a record aimed at it never counts as a producer.
    function automatic logic match(input rec_t r, input logic [ADDR_W-1:0] a);
        return r.wr && (r.addr != '0) && (r.addr == a);
    endfunction

    function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    // Youngest matching stage decides; a younger match that is not ready yet masks older ones.
    function automatic logic [1:0] fwd_sel(input rec_t e, input rec_t m, input rec_t w,
                                           input logic [ADDR_W-1:0] a);
        if (match(e, a))      return (e.tnew == '0) ? 2'd1 : 2'd0;
        else if (match(m, a)) return (m.tnew == '0) ? 2'd2 : 2'd0;
        else if (match(w, a)) return (w.tnew == '0) ? 2'd3 : 2'd0;
        else                  return 2'd0;
    endfunction

    always_comb begin
        stall = 1'b0;
        if (hz.DValid) begin
            stall = (match(e_q, hz.RsAddrD) && (e_q.tnew > hz.RsTuseD)) ||
                    (match(m_q, hz.RsAddrD) && (m_q.tnew > hz.RsTuseD)) ||
                    (match(e_q, hz.RtAddrD) && (e_q.tnew > hz.RtTuseD)) ||
                    (match(m_q, hz.RtAddrD) && (m_q.tnew > hz.RtTuseD));
        end
        fwd_rs = fwd_sel(e_q, m_q, w_q, hz.RsAddrD);
        fwd_rt = fwd_sel(e_q, m_q, w_q, hz.RtAddrD);
    end

    always_comb begin
        w_d      = m_q;
        w_d.tnew = sat_dec(m_q.tnew);
        m_d      = e_q;
        m_d.tnew = sat_dec(e_q.tnew);
        e_d      = '0;
        if (hz.DValid && !stall) begin
            e_d.addr = hz.DstAddrD;
            e_d.wr   = hz.DstWriteD;
            e_d.tnew = hz.DstTnewD;
        end
        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            m_q   <= m_d;
            w_q   <= w_d;
            cnt_q <= cnt_d;
        end
    end

    assign hz.Stall      = stall;
    assign hz.FwdRsD     = fwd_rs;
    assign hz.FwdRtD     = fwd_rt;
    assign hz.StallCount = cnt_q;

endmodule

// File: tb/tb_grf_hazard_unit.sv
// Bench for grf_hazard_unit: per-scenario stimulus tables, expectations queued at drive
// time and popped when the outputs are sampled mid-cycle.
module tb_grf_hazard_unit;

    typedef struct packed {
        bit       rst;
        bit       dv;
        bit [4:0] rs;
        bit [1:0] rsu;
        bit [4:0] rt;
        bit [1:0] rtu;
        bit [4:0] dst;
        bit       wr;
        bit [1:0] tnew;
        bit       chk;
        bit       stall;
        bit [1:0] frs;
        bit [1:0] frt;
    } step_t;

    typedef struct packed {
        bit        chk;
        bit        stall;
        bit [1:0]  frs;
        bit [1:0]  frt;
        bit [31:0] cnt;
    } exp_t;

    localparam step_t FLUSH = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};

    logic  Clk;
    logic  Reset;
    int    checks;
    int    failures;
    int    run_cnt;
    exp_t  sb[$];

    grf_hazard_if hz ();

    grf_hazard_unit dut (
        .Clk  (Clk),
        .Reset(Reset),
        .hz   (hz)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Applies one row and queues what the outputs must show this cycle.
    task automatic drive_row(input step_t s);
        exp_t e;
        Reset        = s.rst;
        hz.DValid    = s.dv;
        hz.RsAddrD   = s.rs;
        hz.RsTuseD   = s.rsu;
        hz.RtAddrD   = s.rt;
        hz.RtTuseD   = s.rtu;
        hz.DstAddrD  = s.dst;
        hz.DstWriteD = s.wr;
        hz.DstTnewD  = s.tnew;
        e.chk   = s.chk;
        e.stall = s.stall;
        e.frs   = s.frs;
        e.frt   = s.frt;
        e.cnt   = run_cnt;
        sb.push_back(e);
        run_cnt = s.rst ? 0 : run_cnt + int'(s.stall);
    endtask

    task automatic test_reset();
        step_t tbl[4] = '{
            '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
            '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0},
            '{0, 1, 5, 0, 6, 0, 0, 0, 0, 1, 0, 0, 0}
        };
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            drive_row(tbl[i]);
            @(negedge Clk);
            e = sb.pop_front();
            if (e.chk) begin
                checks++;
                if ({hz.Stall, hz.FwdRsD, hz.FwdRtD, hz.StallCount} !== {e.stall, e.frs, e.frt, e.cnt}) begin
                    failures++;
                    $display("FAIL reset row%0d: got stall=%0b rs=%0d rt=%0d cnt=%0d, want stall=%0b rs=%0d rt=%0d cnt=%0d",
                             i, hz.Stall, hz.FwdRsD, hz.FwdRtD, hz.StallCount, e.stall, e.frs, e.frt, e.cnt);
                end
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_load_use();
        step_t tbl[4] = '{
            '{0, 1, 1, 3, 2, 3, 5, 1, 2, 1, 0, 0, 0},
            '{0, 1, 5, 0, 0, 0, 6, 1, 1, 1, 1, 0, 0},
            '{0, 1, 5, 0, 0, 0, 6, 1, 1, 1, 1, 0, 0},
            '{0, 1, 5, 0, 0, 0, 6, 1, 1, 1, 0, 3, 0}
        };
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            drive_row(tbl[i]);
            @(negedge Clk);
            e = sb.pop_front();
            if (e.chk) begin
                checks++;
                if ({hz.Stall, hz.FwdRsD, hz.FwdRtD, hz.StallCount} !== {e.stall, e.frs, e.frt, e.cnt}) begin
                    failures++;
                    $display("FAIL load_use row%0d: got stall=%0b rs=%0d rt=%0d cnt=%0d, want stall=%0b rs=%0d rt=%0d cnt=%0d",
                             i, hz.Stall, hz.FwdRsD, hz.FwdRtD, hz.StallCount, e.stall, e.frs, e.frt, e.cnt);
                end
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_alu_chain();
        step_t tbl[7] = '{
            FLUSH, FLUSH, FLUSH,
            '{0, 1, 0, 0, 0, 0, 3, 1, 1, 1, 0, 0, 0},
            '{0, 1, 0, 0, 3, 1, 0, 0, 0, 1, 0, 0, 0},
            '{0, 1, 9, 0, 3, 1, 0, 0, 0, 1, 0, 0, 2},
            '{0, 1, 3, 0, 3, 1, 0, 0, 0, 1, 0, 3, 3}
        };
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            drive_row(tbl[i]);
            @(negedge Clk);
            e = sb.pop_front();
            if (e.chk) begin
                checks++;
                if ({hz.Stall, hz.FwdRsD, hz.FwdRtD, hz.StallCount} !== {e.stall, e.frs, e.frt, e.cnt}) begin
                    failures++;
                    $display("FAIL alu_chain row%0d: got stall=%0b rs=%0d rt=%0d cnt=%0d, want stall=%0b rs=%0d rt=%0d cnt=%0d",
                             i, hz.Stall, hz.FwdRsD, hz.FwdRtD, hz.StallCount, e.stall, e.frs, e.frt, e.cnt);
                end
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_priority();
        step_t tbl[8] = '{
            FLUSH, FLUSH, FLUSH,
            '{0, 1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0},
            '{0, 1, 7, 0, 0, 0, 7, 1, 0, 1, 0, 1, 0},
            '{0, 1, 7, 0, 7, 0, 8, 1, 0, 1, 0, 1, 1},
            '{0, 1, 7, 0, 8, 0, 0, 0, 0, 1, 0, 2, 1},
            '{0, 1, 7, 0, 8, 0, 0, 0, 0, 1, 0, 3, 2}
        };
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            drive_row(tbl[i]);
            @(negedge Clk);
            e = sb.pop_front();
            if (e.chk) begin
                checks++;
                if ({hz.Stall, hz.FwdRsD, hz.FwdRtD, hz.StallCount} !== {e.stall, e.frs, e.frt, e.cnt}) begin
                    failures++;
                    $display("FAIL priority row%0d: got stall=%0b rs=%0d rt=%0d cnt=%0d, want stall=%0b rs=%0d rt=%0d cnt=%0d",
                             i, hz.Stall, hz.FwdRsD, hz.FwdRtD, hz.StallCount, e.stall, e.frs, e.frt, e.cnt);
                end
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_zero_bubble();
        step_t tbl[8] = '{
            FLUSH, FLUSH, FLUSH,
            '{0, 1, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0},
            '{0, 1, 0, 0, 0, 0, 9, 1, 3, 1, 0, 0, 0},
            '{0, 0, 9, 0, 9, 0, 0, 0, 0, 1, 0, 0, 0},
            '{0, 0, 9, 0, 9, 0, 0, 0, 0, 1, 0, 0, 0},
            '{0, 1, 9, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0}
        };
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            drive_row(tbl[i]);
            @(negedge Clk);
            e = sb.pop_front();
            if (e.chk) begin
                checks++;
                if ({hz.Stall, hz.FwdRsD, hz.FwdRtD, hz.StallCount} !== {e.stall, e.frs, e.frt, e.cnt}) begin
                    failures++;
                    $display("FAIL zero_bubble row%0d: got stall=%0b rs=%0d rt=%0d cnt=%0d, want stall=%0b rs=%0d rt=%0d cnt=%0d",
                             i, hz.Stall, hz.FwdRsD, hz.FwdRtD, hz.StallCount, e.stall, e.frs, e.frt, e.cnt);
                end
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_reset_mid_stall();
        step_t tbl[7] = '{
            FLUSH, FLUSH, FLUSH,
            '{0, 1, 0, 0, 0, 0, 5, 1, 2, 1, 0, 0, 0},
            '{0, 1, 5, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0},
            '{1, 1, 5, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0},
            '{0, 1, 5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0}
        };
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            drive_row(tbl[i]);
            @(negedge Clk);
            e = sb.pop_front();
            if (e.chk) begin
                checks++;
                if ({hz.Stall, hz.FwdRsD, hz.FwdRtD, hz.StallCount} !== {e.stall, e.frs, e.frt, e.cnt}) begin
                    failures++;
                    $display("FAIL reset_mid_stall row%0d: got stall=%0b rs=%0d rt=%0d cnt=%0d, want stall=%0b rs=%0d rt=%0d cnt=%0d",
                             i, hz.Stall, hz.FwdRsD, hz.FwdRtD, hz.StallCount, e.stall, e.frs, e.frt, e.cnt);
                end
            end
            @(posedge Clk); #1;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        run_cnt  = 0;
        drive_row('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        void'(sb.pop_front());
        run_cnt = 0;
        @(posedge Clk); #1;
        test_reset();
        test_load_use();
        test_alu_chain();
        test_priority();
        test_zero_bubble();
        test_reset_mid_stall();
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
